hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the pipeline's load-use/multdiv stall logic. Sits between the F/D and D/X pipeline registers and decides when to freeze PC and F/D and inject a bubble into D/X. It tracks the single in-flight multiply/divide with a destination scoreboard, so only dependent or conflicting instructions stall. It also adds a writeback-slot stall and a latency watchdog.

## Interface
Parameters:
- `ADDR_W`, 5: register-address width; register 0 is never a hazard.
- `MAX_LAT`, 40: cycles a multdiv may stay busy before the watchdog fires.
- `STALL_MODE`, 1: 0 = legacy (stall every instruction while multdiv busy); 1 = scoreboard (stall dependent/conflicting only).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fd_insn` in 32: instruction in F/D.
- `fd_valid` in 1: F/D holds a real instruction.
- `dx_insn` in 32: instruction in D/X.
- `dx_valid` in 1: D/X holds a real instruction.
- `md_rdy` in 1: one-cycle pulse; multdiv result is written back this cycle.
- `stall` out 1: freeze PC and F/D, bubble D/X.
- `lw_hazard` out 1: load-use component of `stall`.
- `md_hazard` out 1: multdiv component of `stall` (data, WAW, structural or writeback slot).
- `md_busy` out 1: multdiv in flight.
- `md_dest` out ADDR_W: destination of in-flight multdiv.
- `timeout_err` out 1: sticky watchdog flag.
- `proto_err` out 1: sticky; a multdiv reached D/X while busy.

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- Decode:
  - R-type = opcode 00000; lw = 01000; sw = 00111; bne = 00010; blt = 00110; jr = 00100.
  - mul = R-type with ALU op 00110; div = R-type with ALU op 00111.
- Sources:
  - rs for every opcode except j/jal/setx.
  - rt for R-type.
  - rd for sw, bne, blt, jr.
- Destination (rd) for R-type, addi, lw, jal (r31), setx (r30).
- Any compare against register 0 is false.
- lw_hazard = dx_valid & dx is lw & fd_valid & (a source of fd equals dx rd).
- Scoreboard state: `md_busy`, `md_dest`, latency counter `cnt` (width clog2(MAX_LAT+1)).
- md_hazard, STALL_MODE=1, is the OR of the terms below; each is qualified by fd_valid and by md_busy & ~md_rdy unless stated:
  - RAW: a source of fd equals md_dest.
  - WAW: the destination of fd equals md_dest.
  - Structural: fd is mul/div. This term is qualified by md_busy only, not by ~md_rdy.
  - Writeback slot: md_rdy & fd_valid & (fd writes a register). This holds fd one cycle so its writeback does not collide with the multdiv result.
- md_hazard, STALL_MODE=0: md_busy & ~md_rdy, plus the structural term above.
- stall = lw_hazard | md_hazard.

## Timing
- Reset (asynchronous assert, synchronous release on the next rising edge): md_busy=0, md_dest=0, cnt=0, timeout_err=0, proto_err=0. stall, lw_hazard and md_hazard are therefore 0 unless lw_hazard is driven combinationally.
- stall and the hazard outputs are combinational from the inputs and the registered state, valid in the same cycle.
- Launch: at the rising edge where dx_valid & dx is mul/div, set md_busy<=1, md_dest<=dx rd, cnt<=0.
- Completion: at the edge where md_rdy=1 and no launch occurs, set md_busy<=0.
- Launch and md_rdy in the same cycle: launch wins (busy stays 1, new dest, cnt=0).
- While md_busy & ~md_rdy, cnt increments each cycle.
- Watchdog: when cnt==MAX_LAT-1 and no md_rdy, at the next edge timeout_err<=1 (sticky) and md_busy<=0 so the pipeline recovers.
- Launch while md_busy & ~md_rdy: set proto_err<=1 (sticky); the launch still takes effect.
- md_rdy while not busy: ignored.
- A reset mid-operation drops the scoreboard; the in-flight result is discarded by the multdiv owner.

## Structure
- Shared package `proc_pkg`:
  - opcode and ALU-op constants;
  - field-position constants;
  - functions is_mul, is_div, reads_rd, writes_rd.
- One sub-module `insn_regs`, instantiated twice (fd, dx). It extracts rs/rt/rd and the read/write-enable flags for each instruction.
- Scoreboard registers and the watchdog live in the top module.

## Test plan
- Load-use: dx=lw r5; fd=add r1,r5,r2 -> stall=1, lw_hazard=1. Next cycle, with dx a bubble -> stall=0.
- Dependent stall: launch mul r7 (STALL_MODE=1), md_rdy after 32 cycles; fd=addi r3,r7,1 -> stall=1 for 32 cycles. md_busy falls the edge after md_rdy and md_dest=7 throughout.
- Independent flow and writeback slot: during the same mul, fd=add r1,r2,r3 -> stall=0. On the md_rdy cycle -> stall=1 for exactly 1 cycle. With STALL_MODE=0 the same stimulus -> stall for every busy cycle.
- Structural and simultaneous events:
  - fd=div while busy -> stall until the md_rdy cycle.
  - Launch coinciding with md_rdy -> md_busy stays 1 and md_dest is updated.
- Watchdog: MAX_LAT=8, launch with no md_rdy -> timeout_err=1 after 8 cycles, md_busy=0, stall released. Asserting reset_n low clears timeout_err asynchronously.
- Register 0: dx=lw r0; fd=add r1,r0,r0 -> stall=0. A mul to r0 -> no RAW stall.

Source files
------------

// File: rtl/proc_pkg.sv
// Instruction field positions, opcode/ALU-op constants and decode helpers
// shared by the hazard logic.
package proc_pkg;

   localparam int unsigned FIELD_W = 5;
   localparam int unsigned OPC_LSB = 27;
   localparam int unsigned RD_LSB  = 22;
   localparam int unsigned RS_LSB  = 17;
   localparam int unsigned RT_LSB  = 12;
   localparam int unsigned ALU_LSB = 2;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;

   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam logic [4:0] REG_RA   = 5'd31;
   localparam logic [4:0] REG_STAT = 5'd30;

   function automatic logic [4:0] opcode(input logic [31:0] insn);
      return insn[OPC_LSB +: FIELD_W];
   endfunction

   function automatic logic [4:0] alu_op(input logic [31:0] insn);
      return insn[ALU_LSB +: FIELD_W];
   endfunction

   function automatic logic [4:0] field_rd(input logic [31:0] insn);
      return insn[RD_LSB +: FIELD_W];
   endfunction

   function automatic logic [4:0] field_rs(input logic [31:0] insn);
      return insn[RS_LSB +: FIELD_W];
   endfunction

   function automatic logic [4:0] field_rt(input logic [31:0] insn);
      return insn[RT_LSB +: FIELD_W];
   endfunction

   function automatic logic is_mul(input logic [31:0] insn);
      return (opcode(insn) == OP_RTYPE) && (alu_op(insn) == ALU_MUL);
   endfunction

   function automatic logic is_div(input logic [31:0] insn);
      return (opcode(insn) == OP_RTYPE) && (alu_op(insn) == ALU_DIV);
   endfunction

   function automatic logic is_lw(input logic [31:0] insn);
      return opcode(insn) == OP_LW;
   endfunction

   function automatic logic reads_rs(input logic [31:0] insn);
      logic [4:0] op;
      op = opcode(insn);
      return !((op == OP_J) || (op == OP_JAL) || (op == OP_SETX));
   endfunction

   function automatic logic reads_rt(input logic [31:0] insn);
      return opcode(insn) == OP_RTYPE;
   endfunction

   function automatic logic reads_rd(input logic [31:0] insn);
      logic [4:0] op;
      op = opcode(insn);
      return (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
   endfunction

   function automatic logic writes_rd(input logic [31:0] insn);
      logic [4:0] op;
      op = opcode(insn);
      return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
             (op == OP_JAL) || (op == OP_SETX);
   endfunction

   // jal and setx write fixed registers rather than the rd field.
   function automatic logic [4:0] dest_reg(input logic [31:0] insn);
      logic [4:0] op;
      op = opcode(insn);
      if (op == OP_JAL)       return REG_RA;
      else if (op == OP_SETX) return REG_STAT;
      else                    return field_rd(insn);
   endfunction

endpackage

// File: rtl/insn_regs.sv
// Register-operand decode for one pipeline stage: source/destination addresses and
// their enables. Source enables are already cleared for register 0.
module insn_regs
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W = 5
) (
   input  logic [31:0]       i_insn,
   output logic [ADDR_W-1:0] o_rs,
   output logic [ADDR_W-1:0] o_rt,
   output logic [ADDR_W-1:0] o_rd,
   output logic [ADDR_W-1:0] o_dest,
   output logic              o_rs_en,
   output logic              o_rt_en,
   output logic              o_rd_en,
   output logic              o_wr_en,
   output logic              o_is_lw,
   output logic              o_is_md
);

   always_comb begin
      o_rs    = ADDR_W'(field_rs(i_insn));
      o_rt    = ADDR_W'(field_rt(i_insn));
      o_rd    = ADDR_W'(field_rd(i_insn));
      o_dest  = ADDR_W'(dest_reg(i_insn));
      o_rs_en = reads_rs(i_insn) && (o_rs != '0);
      o_rt_en = reads_rt(i_insn) && (o_rt != '0);
      o_rd_en = reads_rd(i_insn) && (o_rd != '0);
      o_wr_en = writes_rd(i_insn);
      o_is_lw = is_lw(i_insn);
      o_is_md = is_mul(i_insn) || is_div(i_insn);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall decision between F/D and D/X: load-use detection plus a one-entry
// multdiv destination scoreboard with a latency watchdog.
module hazard_scoreboard
   import proc_pkg::*;
#(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned MAX_LAT    = 40,
   parameter int unsigned STALL_MODE = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [31:0]       fd_insn,
   input  logic              fd_valid,
   input  logic [31:0]       dx_insn,
   input  logic              dx_valid,
   input  logic              md_rdy,
   output logic              stall,
   output logic              lw_hazard,
   output logic              md_hazard,
   output logic              md_busy,
   output logic [ADDR_W-1:0] md_dest,
   output logic              timeout_err,
   output logic              proto_err
);

   localparam int unsigned         CNT_W    = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAX_LAT - 1);

   logic [ADDR_W-1:0] w_fd_rs, w_fd_rt, w_fd_rd, w_fd_dest;
   logic              w_fd_rs_en, w_fd_rt_en, w_fd_rd_en, w_fd_wr_en, w_fd_is_lw, w_fd_is_md;
   logic [ADDR_W-1:0] w_dx_rs, w_dx_rt, w_dx_rd, w_dx_dest;
   logic              w_dx_rs_en, w_dx_rt_en, w_dx_rd_en, w_dx_wr_en, w_dx_is_lw, w_dx_is_md;

   logic              r_busy, r_timeout, r_proto;
   logic [ADDR_W-1:0] r_dest;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_busy_nxt, w_timeout_nxt, w_proto_nxt;
   logic [ADDR_W-1:0] w_dest_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   logic w_launch, w_pend, w_last;
   logic w_fd_hit_dx, w_fd_hit_md, w_fd_waw;
   logic w_raw, w_waw, w_struct, w_wb;
   logic w_unused;

   insn_regs #(.ADDR_W(ADDR_W)) u_fd_regs (
      .i_insn  (fd_insn),
      .o_rs    (w_fd_rs),
      .o_rt    (w_fd_rt),
      .o_rd    (w_fd_rd),
      .o_dest  (w_fd_dest),
      .o_rs_en (w_fd_rs_en),
      .o_rt_en (w_fd_rt_en),
      .o_rd_en (w_fd_rd_en),
      .o_wr_en (w_fd_wr_en),
      .o_is_lw (w_fd_is_lw),
      .o_is_md (w_fd_is_md)
   );

   insn_regs #(.ADDR_W(ADDR_W)) u_dx_regs (
      .i_insn  (dx_insn),
      .o_rs    (w_dx_rs),
      .o_rt    (w_dx_rt),
      .o_rd    (w_dx_rd),
      .o_dest  (w_dx_dest),
      .o_rs_en (w_dx_rs_en),
      .o_rt_en (w_dx_rt_en),
      .o_rd_en (w_dx_rd_en),
      .o_wr_en (w_dx_wr_en),
      .o_is_lw (w_dx_is_lw),
      .o_is_md (w_dx_is_md)
   );

   assign w_unused = ^{w_fd_is_lw, w_dx_rs, w_dx_rt, w_dx_rd, w_dx_rs_en, w_dx_rt_en,
                       w_dx_rd_en, w_dx_wr_en};

   // Source enables exclude r0, so a zero-valued target never matches.
   assign w_fd_hit_dx = (w_fd_rs_en && (w_fd_rs == w_dx_dest)) ||
                        (w_fd_rt_en && (w_fd_rt == w_dx_dest)) ||
                        (w_fd_rd_en && (w_fd_rd == w_dx_dest));
   assign w_fd_hit_md = (w_fd_rs_en && (w_fd_rs == r_dest)) ||
                        (w_fd_rt_en && (w_fd_rt == r_dest)) ||
                        (w_fd_rd_en && (w_fd_rd == r_dest));
   assign w_fd_waw    = w_fd_wr_en && (w_fd_dest != '0) && (w_fd_dest == r_dest);

   assign lw_hazard = dx_valid && w_dx_is_lw && fd_valid && w_fd_hit_dx;

   assign w_launch = dx_valid && w_dx_is_md;
   assign w_pend   = r_busy && !md_rdy;
   assign w_last   = w_pend && (r_cnt == CNT_LAST);

   assign w_raw    = fd_valid && w_pend && w_fd_hit_md;
   assign w_waw    = fd_valid && w_pend && w_fd_waw;
   assign w_struct = fd_valid && r_busy && w_fd_is_md;
   // Hold a writer one cycle so its writeback does not collide with the multdiv result.
   assign w_wb     = fd_valid && r_busy && md_rdy && w_fd_wr_en;

   always_comb begin
      md_hazard = 1'b0;
      if (STALL_MODE == 0) md_hazard = w_pend || w_struct;
      else                 md_hazard = w_raw || w_waw || w_struct || w_wb;
   end

   assign stall = lw_hazard || md_hazard;

   always_comb begin
      w_busy_nxt    = r_busy;
      w_dest_nxt    = r_dest;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = r_timeout || w_last;
      w_proto_nxt   = r_proto;
      if (w_launch) begin
         w_busy_nxt = 1'b1;
         w_dest_nxt = w_dx_dest;
         w_cnt_nxt  = '0;
         if (w_pend) w_proto_nxt = 1'b1;
      end else if (r_busy && md_rdy) begin
         w_busy_nxt = 1'b0;
         w_cnt_nxt  = '0;
      end else if (w_last) begin
         w_busy_nxt = 1'b0;
         w_cnt_nxt  = '0;
      end else if (w_pend) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_busy    <= 1'b0;
         r_dest    <= '0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
         r_proto   <= 1'b0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_dest    <= w_dest_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
         r_proto   <= w_proto_nxt;
      end
   end

   assign md_busy     = r_busy;
   assign md_dest     = r_dest;
   assign timeout_err = r_timeout;
   assign proto_err   = r_proto;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default, legacy-mode and short-watchdog instances share one stimulus.
module tb_hazard_scoreboard;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] fd_insn = '0;
   logic        fd_valid = 1'b0;
   logic [31:0] dx_insn = '0;
   logic        dx_valid = 1'b0;
   logic        md_rdy = 1'b0;

   logic       stall_d, lw_d, mdh_d, busy_d, to_d, pe_d;
   logic [4:0] dest_d;
   logic       stall_l, lw_l, mdh_l, busy_l, to_l, pe_l;
   logic [4:0] dest_l;
   logic       stall_w, lw_w, mdh_w, busy_w, to_w, pe_w;
   logic [4:0] dest_w;

   int n_total = 0;
   int n_bad   = 0;
   int n_s, n_l;

   always #5 clock = ~clock;

   hazard_scoreboard u_dut (
      .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .fd_valid(fd_valid),
      .dx_insn(dx_insn), .dx_valid(dx_valid), .md_rdy(md_rdy), .stall(stall_d),
      .lw_hazard(lw_d), .md_hazard(mdh_d), .md_busy(busy_d), .md_dest(dest_d),
      .timeout_err(to_d), .proto_err(pe_d)
   );

   hazard_scoreboard #(.STALL_MODE(0)) u_leg (
      .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .fd_valid(fd_valid),
      .dx_insn(dx_insn), .dx_valid(dx_valid), .md_rdy(md_rdy), .stall(stall_l),
      .lw_hazard(lw_l), .md_hazard(mdh_l), .md_busy(busy_l), .md_dest(dest_l),
      .timeout_err(to_l), .proto_err(pe_l)
   );

   hazard_scoreboard #(.MAX_LAT(8)) u_wd (
      .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .fd_valid(fd_valid),
      .dx_insn(dx_insn), .dx_valid(dx_valid), .md_rdy(md_rdy), .stall(stall_w),
      .lw_hazard(lw_w), .md_hazard(mdh_w), .md_busy(busy_w), .md_dest(dest_w),
      .timeout_err(to_w), .proto_err(pe_w)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] alu);
      return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      fd_valid = 1'b0;
      dx_valid = 1'b0;
      md_rdy   = 1'b0;
      fd_insn  = '0;
      dx_insn  = '0;
      cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   // One-cycle mul in D/X; returns one time unit after the launch edge.
   task automatic launch(input logic [4:0] rd);
      dx_insn  = rtype(rd, 5'd1, 5'd2, 5'b00110);
      dx_valid = 1'b1;
      cyc();
      dx_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_stall", stall_d, 0);
      check("rst_busy", busy_d, 0);
      check("rst_dest", dest_d, 0);
      check("rst_timeout", to_d, 0);
      check("rst_proto", pe_d, 0);
      do_reset();

      // Load-use
      dx_insn  = itype(5'b01000, 5'd5, 5'd0, 17'd0);
      dx_valid = 1'b1;
      fd_insn  = rtype(5'd1, 5'd5, 5'd2, 5'd0);
      fd_valid = 1'b1;
      #1;
      check("lu_stall", stall_d, 1);
      check("lu_lw", lw_d, 1);
      check("lu_md", mdh_d, 0);
      fd_insn = rtype(5'd1, 5'd2, 5'd5, 5'd0);
      #1;
      check("lu_rt_stall", stall_d, 1);
      cyc();
      dx_valid = 1'b0;
      #1;
      check("lu_bubble", stall_d, 0);
      // r0 never hazards
      dx_insn  = itype(5'b01000, 5'd0, 5'd3, 17'd0);
      dx_valid = 1'b1;
      fd_insn  = rtype(5'd1, 5'd0, 5'd0, 5'd0);
      #1;
      check("lu_r0", stall_d, 0);
      dx_valid = 1'b0;
      fd_valid = 1'b0;
      cyc();

      // Dependent stall: addi r3,r7,1 behind mul r7
      launch(5'd7);
      fd_insn  = itype(5'b00101, 5'd3, 5'd7, 17'd1);
      fd_valid = 1'b1;
      n_s = 0;
      n_l = 0;
      for (int i = 1; i <= 32; i++) begin
         md_rdy = (i == 32);
         #1;
         if (stall_d) n_s++;
         if (stall_l) n_l++;
         check("dep_busy", busy_d, 1);
         check("dep_dest", dest_d, 7);
         cyc();
      end
      md_rdy = 1'b0;
      #1;
      check("dep_count", n_s, 32);
      check("dep_leg_count", n_l, 31);
      check("dep_busy_fall", busy_d, 0);
      check("dep_release", stall_d, 0);

      // Independent add: only the writeback-slot cycle stalls
      fd_valid = 1'b0;
      launch(5'd7);
      fd_insn  = rtype(5'd1, 5'd2, 5'd3, 5'd0);
      fd_valid = 1'b1;
      n_s = 0;
      n_l = 0;
      for (int i = 1; i <= 32; i++) begin
         md_rdy = (i == 32);
         #1;
         if (stall_l) n_l++;
         check("ind_stall", stall_d, (i == 32) ? 1 : 0);
         cyc();
      end
      md_rdy = 1'b0;
      #1;
      check("ind_leg_count", n_l, 31);
      check("ind_busy", busy_d, 0);

      // Simultaneous launch and md_rdy, then a protocol violation
      do_reset();
      launch(5'd7);
      cyc();
      dx_insn  = rtype(5'd12, 5'd1, 5'd2, 5'b00111);
      dx_valid = 1'b1;
      md_rdy   = 1'b1;
      cyc();
      dx_valid = 1'b0;
      md_rdy   = 1'b0;
      #1;
      check("sim_busy", busy_d, 1);
      check("sim_dest", dest_d, 12);
      check("sim_proto", pe_d, 0);
      launch(5'd13);
      #1;
      check("proto_dest", dest_d, 13);
      check("proto_err", pe_d, 1);
      md_rdy = 1'b1;
      cyc();
      md_rdy = 1'b0;
      #1;
      check("proto_clear_busy", busy_d, 0);

      // Structural: div in F/D stalls through the md_rdy cycle
      launch(5'd7);
      fd_insn  = rtype(5'd9, 5'd1, 5'd2, 5'b00111);
      fd_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         md_rdy = (i == 5);
         #1;
         check("struct_stall", stall_d, 1);
         cyc();
      end
      md_rdy = 1'b0;
      #1;
      check("struct_release", stall_d, 0);

      // mul to r0 never causes RAW
      do_reset();
      launch(5'd0);
      fd_insn  = rtype(5'd1, 5'd0, 5'd0, 5'd0);
      fd_valid = 1'b1;
      #1;
      check("r0_busy", busy_d, 1);
      check("r0_stall", stall_d, 0);

      // Watchdog on the MAX_LAT=8 instance
      do_reset();
      launch(5'd4);
      for (int i = 1; i <= 8; i++) begin
         cyc();
         #1;
         check("wd_timeout", to_w, (i == 8) ? 1 : 0);
      end
      check("wd_busy", busy_w, 0);
      check("wd_dflt_busy", busy_d, 1);
      fd_insn  = rtype(5'd1, 5'd4, 5'd2, 5'd0);
      fd_valid = 1'b1;
      #1;
      check("wd_stall", stall_w, 0);
      check("dflt_stall", stall_d, 1);
      reset_n = 1'b0;
      #1;
      check("wd_async_clr", to_w, 0);
      check("rst_drop_busy", busy_d, 0);
      cyc();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
